// File: rtl/upsample_pkg.sv
// Shared definitions for the upsampler output-stream slice.
//   ADDR_W   : frame buffer address width (depth = 2**ADDR_W words)
//   SIZE_MAX : largest legal size_upsample code
//   BASE_W   : row width for size code 0; row width = BASE_W << code
//   state_e  : output-stream controller states
//   beat_tag_t : per-beat sideband (tlast/tuser) travelling with the read data
package upsample_pkg;

  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned SIZE_MAX = 4;
  localparam int unsigned BASE_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  typedef struct packed {
    logic last;
    logic user;
  } beat_tag_t;

  function automatic int unsigned row_width(input logic [2:0] code);
    return BASE_W << code;
  endfunction

endpackage

// File: rtl/upsample_frame_ram.sv
// Simple dual-port frame buffer: one write port, one read port with a
// registered read (data valid the cycle after re_i).
//   clk_i              : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i       : read request
//   rdata_o            : read data, 1-cycle latency, held while re_i is low
module upsample_frame_ram #(
  parameter int unsigned length = 16,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [length-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [length-1:0] rdata_o
);

  logic [length-1:0] mem_q [0:(1 << ADDR_W) - 1];
  logic [length-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/upsample_out_stream.sv
// Captures scattered upsampler writes into a local frame buffer, then drains
// the frame in raster order as an AXI4-Stream master with backpressure.
//   clk, rst (sync, active low)
//   start, size_upsample       : arm a new frame; W = 8 << size, N = W*W
//   up_data/up_addr/up_we/up_done : upsampler write interface
//   m_axis_tdata/tvalid/tready/tlast/tuser : output stream
//   busy       : high from accepted start until the last beat is accepted
//   frame_done : one-cycle pulse after the final handshake
//   err        : sticky illegal-size / stray-write flag
module upsample_out_stream #(
  parameter int unsigned length = 16,
  parameter int unsigned ADDR_W = upsample_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        size_upsample,
  input  logic [length-1:0] up_data,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic              up_we,
  input  logic              up_done,
  output logic [length-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  import upsample_pkg::*;

  localparam int unsigned NW = ADDR_W + 1;        // holds N up to 2**ADDR_W
  localparam int unsigned CW = (ADDR_W + 1) / 2;  // holds W-1

  state_e            state_q, state_d;
  logic [CW-1:0]     wlast_q, wlast_d;
  logic [NW-1:0]     n_q, n_d;
  logic              err_q, err_d;
  logic              fd_q, fd_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     row_q, row_d;

  // Read in flight: data appears on ram_rdata the cycle after issue.
  logic              rv_q, rv_d;
  beat_tag_t         rtag_q, rtag_d;

  // Two-entry output stage: out_* drives the bus, skid_* catches a read
  // that lands while the bus is stalled.
  logic [length-1:0] out_q, out_d, skid_q, skid_d;
  beat_tag_t         out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic              out_v_q, out_v_d, skid_v_q, skid_v_d;

  logic              ram_we, ram_re;
  logic [length-1:0] ram_rdata;
  logic              pop, space, size_ok, addr_ok, last_rd;
  logic [1:0]        occ;

  upsample_frame_ram #(
    .length (length),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (up_addr),
    .wdata_i (up_data),
    .re_i    (ram_re),
    .raddr_i (rd_q),
    .rdata_o (ram_rdata)
  );

  assign pop     = out_v_q & m_axis_tready;
  assign occ     = 2'(out_v_q) + 2'(skid_v_q) + 2'(rv_q);
  // Issue only if, after this cycle's pop, the new read still fits in
  // the two output entries.
  assign space   = (occ < 2'd2) || ((occ == 2'd2) && pop);
  assign size_ok = (size_upsample <= 3'(SIZE_MAX));
  assign addr_ok = ({1'b0, up_addr} < n_q);
  assign last_rd = (row_q == wlast_q) && (col_q == wlast_q);
  assign ram_we  = (state_q == ST_FILL) && up_we && addr_ok;

  // Controller: state, frame geometry, counters, flags.
  always_comb begin
    state_d = state_q;
    wlast_d = wlast_q;
    n_d     = n_q;
    err_d   = err_q;
    fd_d    = 1'b0;
    rd_d    = rd_q;
    col_d   = col_q;
    row_d   = row_q;
    ram_re  = 1'b0;
    rtag_d  = rtag_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (size_ok) begin
            wlast_d = CW'(row_width(size_upsample) - 1);
            n_d     = NW'(row_width(size_upsample) * row_width(size_upsample));
            err_d   = 1'b0;
            state_d = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (up_we && !addr_ok) err_d = 1'b1;
        if (up_done) begin
          rd_d    = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (space) begin
          ram_re      = 1'b1;
          rtag_d.last = (col_q == wlast_q);
          rtag_d.user = (rd_q == '0);
          rd_d        = rd_q + 1'b1;
          if (col_q == wlast_q) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_rd) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (pop && !skid_v_q && !rv_q) begin
          fd_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stray write wins over the clear from a start in the same cycle.
    if (up_we && (state_q != ST_FILL)) err_d = 1'b1;
  end

  assign rv_d = ram_re;

  // Output stage: refill the bus register from skid first, then from RAM.
  always_comb begin
    out_d      = out_q;
    out_tag_d  = out_tag_q;
    out_v_d    = out_v_q;
    skid_d     = skid_q;
    skid_tag_d = skid_tag_q;
    skid_v_d   = skid_v_q;

    if (!out_v_q || pop) begin
      if (skid_v_q) begin
        out_d     = skid_q;
        out_tag_d = skid_tag_q;
        out_v_d   = 1'b1;
        skid_v_d  = rv_q;
        if (rv_q) begin
          skid_d     = ram_rdata;
          skid_tag_d = rtag_q;
        end
      end else if (rv_q) begin
        out_d     = ram_rdata;
        out_tag_d = rtag_q;
        out_v_d   = 1'b1;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (rv_q) begin
      skid_d     = ram_rdata;
      skid_tag_d = rtag_q;
      skid_v_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wlast_q    <= '0;
      n_q        <= '0;
      err_q      <= 1'b0;
      fd_q       <= 1'b0;
      rd_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rv_q       <= 1'b0;
      rtag_q     <= '0;
      out_q      <= '0;
      out_tag_q  <= '0;
      out_v_q    <= 1'b0;
      skid_q     <= '0;
      skid_tag_q <= '0;
      skid_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wlast_q    <= wlast_d;
      n_q        <= n_d;
      err_q      <= err_d;
      fd_q       <= fd_d;
      rd_q       <= rd_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rv_q       <= rv_d;
      rtag_q     <= rtag_d;
      out_q      <= out_d;
      out_tag_q  <= out_tag_d;
      out_v_q    <= out_v_d;
      skid_q     <= skid_d;
      skid_tag_q <= skid_tag_d;
      skid_v_q   <= skid_v_d;
    end
  end

  assign m_axis_tdata  = out_q;
  assign m_axis_tvalid = out_v_q;
  assign m_axis_tlast  = out_tag_q.last;
  assign m_axis_tuser  = out_tag_q.user;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = fd_q;
  assign err           = err_q;

endmodule

// File: tb/tb_upsample_out_stream.sv
module tb_upsample_out_stream;

  localparam int unsigned LEN = 16;
  localparam int unsigned AW  = 14;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     size_upsample = '0;
  logic [LEN-1:0] up_data = '0;
  logic [AW-1:0]  up_addr = '0;
  logic           up_we = 1'b0;
  logic           up_done = 1'b0;
  logic [LEN-1:0] m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b0;
  logic           m_axis_tlast;
  logic           m_axis_tuser;
  logic           busy;
  logic           frame_done;
  logic           err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  upsample_out_stream #(
    .length (LEN),
    .ADDR_W (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .size_upsample (size_upsample),
    .up_data       (up_data),
    .up_addr       (up_addr),
    .up_we         (up_we),
    .up_done       (up_done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .busy          (busy),
    .frame_done    (frame_done),
    .err           (err)
  );

  // Reference frame contents: what the upsampler legitimately wrote.
  logic [LEN-1:0] model [16384];

  // Beats observed by the collector.
  logic [LEN-1:0] got_d [$];
  bit             got_l [$];
  bit             got_u [$];
  int first_valid_c, fd_c, last_hs_c, stall_viol, fd_count, first_bad;
  bit busy_mid, busy_at_fd, timed_out;

  function automatic int unsigned frame_w(input int unsigned s);
    return 8 << s;
  endfunction

  // Compares the collected stream with the raster-order frame model.
  function automatic int count_bad_beats(input int unsigned s);
    int unsigned w = frame_w(s);
    int unsigned n = w * w;
    int bad = 0;
    first_bad = -1;
    if (got_d.size() != n) bad++;
    for (int i = 0; i < got_d.size(); i++) begin
      if (i >= int'(n) || got_d[i] !== model[i] ||
          got_l[i] !== ((i % w) == w - 1) || got_u[i] !== (i == 0)) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int unsigned s);
    start = 1'b1;
    size_upsample = 3'(s);
    tick();
    start = 1'b0;
  endtask

  // Writes every address once in a shuffled order with occasional idle
  // cycles; the final write is driven together with up_done and left for
  // the caller's next edge. bad_addr >= 0 inserts one out-of-frame write.
  task automatic fill_frame(input int unsigned s, input bit data_is_index, input int bad_addr);
    int unsigned n = frame_w(s) * frame_w(s);
    int unsigned perm [];
    int unsigned j, t;
    perm = new[n];
    for (int unsigned i = 0; i < n; i++) perm[i] = i;
    for (int unsigned i = n - 1; i > 0; i--) begin
      j = $urandom_range(i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int unsigned i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) begin
        up_we = 1'b0;
        tick();
      end
      if (bad_addr >= 0 && i == n / 2) begin
        up_we = 1'b1;
        up_addr = AW'(bad_addr);
        up_data = LEN'($urandom);
        tick();
      end
      up_we = 1'b1;
      up_addr = AW'(perm[i]);
      up_data = data_is_index ? LEN'(perm[i]) : LEN'($urandom);
      model[perm[i]] = up_data;
      if (i == n - 1) up_done = 1'b1;
      else tick();
    end
  endtask

  // Consumes the stream with the given ready probability. Sample c=0 is
  // the first sample after the edge that enters DRAIN.
  task automatic collect(input int unsigned ready_pct, input int max_cycles, input int inject_we_c);
    logic [LEN-1:0] hd;
    bit hl, hu, holding, rdy;
    got_d.delete(); got_l.delete(); got_u.delete();
    first_valid_c = -1; fd_c = -1; last_hs_c = -1;
    stall_viol = 0; fd_count = 0;
    busy_mid = 1'b0; busy_at_fd = 1'b1; timed_out = 1'b1; holding = 1'b0;
    hd = '0; hl = 1'b0; hu = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      tick();
      up_done = 1'b0;
      if (c == inject_we_c) begin
        up_we = 1'b1;
        up_addr = AW'(63);
        up_data = ~model[63];
      end else begin
        up_we = 1'b0;
      end
      if (holding && (!m_axis_tvalid || m_axis_tdata !== hd ||
                      m_axis_tlast !== hl || m_axis_tuser !== hu)) stall_viol++;
      if (m_axis_tvalid && first_valid_c < 0) begin
        first_valid_c = c;
        busy_mid = busy;
      end
      if (frame_done) begin
        fd_count++;
        if (fd_c < 0) begin
          fd_c = c;
          busy_at_fd = busy;
        end
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (m_axis_tvalid && rdy) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
        got_u.push_back(m_axis_tuser);
        last_hs_c = c;
      end
      holding = m_axis_tvalid && !rdy;
      hd = m_axis_tdata; hl = m_axis_tlast; hu = m_axis_tuser;
      m_axis_tready = rdy;
      if (fd_c >= 0 && c >= fd_c + 2) begin
        timed_out = 1'b0;
        break;
      end
    end
    m_axis_tready = 1'b0;
    up_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== '0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
    checks++; if (m_axis_tuser !== 1'b0) begin failures++; $display("FAIL reset_tuser got=%b exp=0", m_axis_tuser); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_size0_ordered();
    int bad, nl;
    do_start(0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL s0_busy_after_start got=%b exp=1", busy); end
    // start while in FILL must be ignored, even with an illegal code
    do_start(7);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL s0_start_in_fill_err got=%b exp=0", err); end
    fill_frame(0, 1'b1, -1);
    collect(100, 200, -1);
    bad = count_bad_beats(0);
    checks++; if (bad !== 0) begin failures++; $display("FAIL s0_beats got=%0d bad (first %0d, n=%0d) exp=0", bad, first_bad, got_d.size()); end
    nl = 0;
    foreach (got_l[i]) if (got_l[i]) nl++;
    checks++; if (nl !== 8) begin failures++; $display("FAIL s0_tlast_count got=%0d exp=8", nl); end
    checks++; if (first_valid_c !== 2) begin failures++; $display("FAIL s0_first_valid got=%0d exp=2", first_valid_c); end
    checks++; if (fd_c !== 66) begin failures++; $display("FAIL s0_frame_done_cycle got=%0d exp=66", fd_c); end
    checks++; if (fd_c !== last_hs_c + 1) begin failures++; $display("FAIL s0_fd_after_last got=%0d exp=%0d", fd_c, last_hs_c + 1); end
    checks++; if (fd_count !== 1) begin failures++; $display("FAIL s0_fd_pulse got=%0d exp=1", fd_count); end
    checks++; if (busy_mid !== 1'b1) begin failures++; $display("FAIL s0_busy_mid got=%b exp=1", busy_mid); end
    checks++; if (busy_at_fd !== 1'b0) begin failures++; $display("FAIL s0_busy_at_fd got=%b exp=0", busy_at_fd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL s0_err got=%b exp=0", err); end
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL s0_timeout got=%b exp=0", timed_out); end
  endtask

  task automatic test_bad_size();
    int vseen, bad;
    do_start(5);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL badsize_err got=%b exp=1", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL badsize_busy got=%b exp=0", busy); end
    vseen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_axis_tvalid || busy) vseen++;
    end
    checks++; if (vseen !== 0) begin failures++; $display("FAIL badsize_idle got=%0d active cycles exp=0", vseen); end
    do_start(1);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL size1_err_cleared got=%b exp=0", err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL size1_busy got=%b exp=1", busy); end
    fill_frame(1, 1'b0, -1);
    collect(70, 2000, -1);
    bad = count_bad_beats(1);
    checks++; if (bad !== 0) begin failures++; $display("FAIL size1_beats got=%0d bad (first %0d, n=%0d) exp=0", bad, first_bad, got_d.size()); end
    checks++; if (stall_viol !== 0) begin failures++; $display("FAIL size1_stall got=%0d exp=0", stall_viol); end
    checks++; if (fd_count !== 1) begin failures++; $display("FAIL size1_fd_pulse got=%0d exp=1", fd_count); end
  endtask

  task automatic test_stray_writes();
    int bad;
    // Out-of-frame address during FILL
    do_start(0);
    fill_frame(0, 1'b0, 64);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oob_write_err got=%b exp=1", err); end
    collect(100, 200, -1);
    bad = count_bad_beats(0);
    checks++; if (bad !== 0) begin failures++; $display("FAIL oob_beats got=%0d bad (first %0d) exp=0", bad, first_bad); end
    // Write during DRAIN to a not-yet-streamed address
    do_start(0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL start_clears_err got=%b exp=0", err); end
    fill_frame(0, 1'b0, -1);
    collect(100, 200, 20);
    bad = count_bad_beats(0);
    checks++; if (bad !== 0) begin failures++; $display("FAIL drain_write_beats got=%0d bad (first %0d) exp=0", bad, first_bad); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL drain_write_err got=%b exp=1", err); end
  endtask

  task automatic test_random_ready();
    int bad, nl;
    do_start(2);
    fill_frame(2, 1'b0, -1);
    collect(50, 5000, -1);
    bad = count_bad_beats(2);
    checks++; if (bad !== 0) begin failures++; $display("FAIL rr_beats got=%0d bad (first %0d, n=%0d) exp=0", bad, first_bad, got_d.size()); end
    nl = 0;
    foreach (got_l[i]) if (got_l[i]) nl++;
    checks++; if (nl !== 32) begin failures++; $display("FAIL rr_tlast_count got=%0d exp=32", nl); end
    checks++; if (stall_viol !== 0) begin failures++; $display("FAIL rr_stall_stability got=%0d exp=0", stall_viol); end
    checks++; if (first_valid_c !== 2) begin failures++; $display("FAIL rr_first_valid got=%0d exp=2", first_valid_c); end
    checks++; if (fd_count !== 1) begin failures++; $display("FAIL rr_fd_pulse got=%0d exp=1", fd_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rr_err got=%b exp=0", err); end
  endtask

  task automatic test_full_rate();
    int bad;
    do_start(4);
    fill_frame(4, 1'b0, -1);
    collect(100, 17000, -1);
    bad = count_bad_beats(4);
    checks++; if (bad !== 0) begin failures++; $display("FAIL full_beats got=%0d bad (first %0d, n=%0d) exp=0", bad, first_bad, got_d.size()); end
    checks++; if (fd_c !== 16386) begin failures++; $display("FAIL full_drain_cycles got=%0d exp=16386", fd_c); end
    checks++; if (last_hs_c - first_valid_c !== 16383) begin failures++; $display("FAIL full_sustained got=%0d exp=16383", last_hs_c - first_valid_c); end
    checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL full_timeout got=%b exp=0", timed_out); end
  endtask

  task automatic test_reset_mid_drain();
    int hs, bad;
    bit rdy;
    do_start(0);
    fill_frame(0, 1'b0, -1);
    hs = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      up_done = 1'b0;
      up_we = 1'b0;
      if (hs == 10) begin
        m_axis_tready = 1'b0;
        break;
      end
      rdy = m_axis_tvalid;
      if (rdy) hs++;
      m_axis_tready = rdy;
    end
    m_axis_tready = 1'b0;
    checks++; if (hs !== 10) begin failures++; $display("FAIL rstmid_reach_beat10 got=%0d exp=10", hs); end
    tick(); tick();
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== model[10]) begin
      failures++; $display("FAIL rstmid_stalled_beat got=%b/%h exp=1/%h", m_axis_tvalid, m_axis_tdata, model[10]);
    end
    rst = 1'b0;
    tick();
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    rst = 1'b1;
    tick();
    do_start(0);
    fill_frame(0, 1'b0, -1);
    collect(80, 400, -1);
    bad = count_bad_beats(0);
    checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_next_frame got=%0d bad (first %0d) exp=0", bad, first_bad); end
    checks++; if (fd_count !== 1) begin failures++; $display("FAIL rstmid_next_fd got=%0d exp=1", fd_count); end
  endtask

  initial begin
    test_reset();
    test_size0_ordered();
    test_bad_size();
    test_stray_writes();
    test_random_ready();
    test_full_rate();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
